// File: rtl/ram_sync_init.sv
// rtl/ram_sync_init.sv - single-port sync RAM with req/ready handshake and hardware init sweep.
// Optional per-word even parity with error injection when RAM_PARITY_EN is defined.
module ram_sync_init #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int WRITE_THROUGH = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef RAM_PARITY_EN
  input  logic                  err_inject,
  output logic                  parity_err,
`endif
  output logic                  ready,
  output logic                  busy,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  addr_err
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  // One extra bit lets a sweep over 2**ADDR_WIDTH words finish without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   init_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign ready    = (state == S_IDLE) && !clear;
  assign accept   = req && ready;
  assign in_range = {1'b0, addr} < DEPTH_L;

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic mem_wpar;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
`ifdef RAM_PARITY_EN
    mem_wpar  = (^wdata) ^ err_inject;
`endif
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr[ADDR_WIDTH-1:0];
      mem_wdata = INIT_VALUE;
`ifdef RAM_PARITY_EN
      mem_wpar  = ^INIT_VALUE;
`endif
    end else if (accept && we && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage is never reset; the init sweep is what defines its contents.
  always_ff @(posedge clk_2) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_PARITY_EN
      par_mem[mem_waddr] <= mem_wpar;
`endif
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state      <= S_INIT;
      init_addr  <= '0;
      busy       <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
      addr_err   <= 1'b0;
`ifdef RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rvalid     <= 1'b0;
      addr_err   <= 1'b0;
`ifdef RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == LAST_L) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clear) begin
            state     <= S_INIT;
            init_addr <= '0;
            busy      <= 1'b1;
          end else if (accept) begin
            addr_err <= !in_range;
            if (!we) begin
              rvalid <= 1'b1;
              rdata  <= in_range ? mem[addr] : '0;
`ifdef RAM_PARITY_EN
              parity_err <= in_range && ((^mem[addr]) ^ par_mem[addr]);
`endif
            end else if (WRITE_THROUGH != 0) begin
              rvalid <= 1'b1;
              rdata  <= wdata;
            end
          end
        end
        default: begin
          state <= S_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_init.sv
// tb/tb_ram_sync_init.sv - self-checking bench for ram_sync_init.
// u0: DEPTH 16, no write-through; u1: DEPTH 12, write-through, INIT_VALUE 8'h5A.
module tb_ram_sync_init;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       rv;
    logic [7:0] rd;
    logic       ae;
    logic       cd;
  } vec_t;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       ae;
    logic       cd;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;

  logic       clear0 = 1'b0, req0 = 1'b0, we0 = 1'b0;
  logic [3:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic       ready0, busy0, rvalid0, addr_err0;
  logic [7:0] rdata0;

  logic       clear1 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       ready1, busy1, rvalid1, addr_err1;
  logic [7:0] rdata1;

`ifdef RAM_PARITY_EN
  logic err_inject0 = 1'b0, err_inject1 = 1'b0;
  logic parity_err0, parity_err1;
`endif

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sbq[$];
  vec_t tab0[24];
  vec_t tab1[9];

  always #5 clk_2 = ~clk_2;

  ram_sync_init #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .WRITE_THROUGH(0), .INIT_VALUE(8'h00)) u0 (
    .clk_2(clk_2), .reset(reset), .clear(clear0), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef RAM_PARITY_EN
    .err_inject(err_inject0), .parity_err(parity_err0),
`endif
    .ready(ready0), .busy(busy0), .rvalid(rvalid0), .rdata(rdata0), .addr_err(addr_err0)
  );

  ram_sync_init #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .WRITE_THROUGH(1), .INIT_VALUE(8'h5A)) u1 (
    .clk_2(clk_2), .reset(reset), .clear(clear1), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
`ifdef RAM_PARITY_EN
    .err_inject(err_inject1), .parity_err(parity_err1),
`endif
    .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1), .addr_err(addr_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one access at a negedge, queue its expectation, compare at the next negedge.
  task automatic run_vec(input int sel, input string tag, input vec_t v);
    exp_t e;
    if (sel == 0) begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end
    sbq.push_back('{v.rv, v.rd, v.ae, v.cd});
    @(negedge clk_2);
    e = sbq.pop_front();
    chk({tag, " addr_err"}, (sel == 0) ? addr_err0 : addr_err1, e.ae);
    if (e.cd) begin
      chk({tag, " rvalid"}, (sel == 0) ? rvalid0 : rvalid1, e.rv);
      chk({tag, " rdata"}, (sel == 0) ? rdata0 : rdata1, e.rd);
    end
  endtask

  // Count negedges with busy high, starting at the current one, until both instances idle.
  task automatic count_busy(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (!busy0 && !busy1) break;
      @(negedge clk_2);
    end
  endtask

  initial begin
    int n0, n1;

    for (int i = 0; i < 16; i++) tab0[i] = '{1'b0, 4'(i), 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tab0[16] = '{1'b1, 4'd3,  8'hA5, 1'b0, 8'h00, 1'b0, 1'b1};
    tab0[17] = '{1'b0, 4'd3,  8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
    tab0[18] = '{1'b1, 4'd7,  8'h5A, 1'b0, 8'hA5, 1'b0, 1'b1};
    tab0[19] = '{1'b0, 4'd7,  8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};
    tab0[20] = '{1'b0, 4'd3,  8'h00, 1'b1, 8'hA5, 1'b0, 1'b1};
    tab0[21] = '{1'b1, 4'd15, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b1};
    tab0[22] = '{1'b1, 4'd15, 8'h0F, 1'b0, 8'hA5, 1'b0, 1'b1};
    tab0[23] = '{1'b0, 4'd15, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b1};

    tab1[0] = '{1'b0, 4'd0,  8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};
    tab1[1] = '{1'b1, 4'd2,  8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1};
    tab1[2] = '{1'b0, 4'd2,  8'h00, 1'b1, 8'h3C, 1'b0, 1'b1};
    tab1[3] = '{1'b1, 4'd13, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0};
    tab1[4] = '{1'b0, 4'd13, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
    tab1[5] = '{1'b0, 4'd11, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};
    tab1[6] = '{1'b0, 4'd12, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1};
    tab1[7] = '{1'b0, 4'd2,  8'h00, 1'b1, 8'h3C, 1'b0, 1'b1};
    tab1[8] = '{1'b0, 4'd1,  8'h00, 1'b1, 8'h5A, 1'b0, 1'b1};

    // Reset state
    #23;
    chk("reset busy", busy0, 1'b1);
    chk("reset ready", ready0, 1'b0);
    chk("reset rvalid", rvalid0, 1'b0);
    chk("reset rdata", rdata0, 8'h00);
    chk("reset addr_err", addr_err0, 1'b0);
    chk("reset busy u1", busy1, 1'b1);

    @(negedge clk_2);
    reset = 1'b1;
    count_busy(n0, n1);
    chk("init cycles u0", n0, 16);
    chk("init cycles u1", n1, 12);
    chk("ready after init", ready0, 1'b1);

    for (int i = 0; i < 24; i++) run_vec(0, $sformatf("u0 vec%0d", i), tab0[i]);
    req0 = 1'b0;
    @(negedge clk_2);
    chk("u0 rvalid single strobe", rvalid0, 1'b0);
    chk("u0 rdata holds", rdata0, 8'h0F);

    for (int i = 0; i < 9; i++) run_vec(1, $sformatf("u1 vec%0d", i), tab1[i]);
    req1 = 1'b0;
    @(negedge clk_2);
    chk("u1 rvalid idle", rvalid1, 1'b0);
    chk("u1 addr_err idle", addr_err1, 1'b0);

    // clear and req together: access refused, sweep reruns
    clear0 = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    #1 chk("ready low with clear", ready0, 1'b0);
    @(negedge clk_2);
    clear0 = 1'b0; req0 = 1'b0;
    chk("clear no rvalid", rvalid0, 1'b0);
    count_busy(n0, n1);
    chk("clear sweep cycles", n0, 16);
    run_vec(0, "after clear addr3", '{1'b0, 4'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    run_vec(0, "after clear addr7", '{1'b0, 4'd7, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    req0 = 1'b0;

    // Reset in IDLE aborts a pending rvalid
    run_vec(0, "pre-reset write", '{1'b1, 4'd4, 8'h99, 1'b0, 8'h00, 1'b0, 1'b1});
    we0 = 1'b0; addr0 = 4'd4;
    @(posedge clk_2);
    #2 reset = 1'b0;
    req0 = 1'b0;
    #1 chk("reset aborts rvalid", rvalid0, 1'b0);
    chk("reset clears rdata", rdata0, 8'h00);
    chk("reset sets busy", busy0, 1'b1);
    @(negedge clk_2);
    reset = 1'b1;

    // Reset pulsed at init cycle 5 restarts the sweep
    repeat (5) @(negedge clk_2);
    chk("mid-sweep busy", busy0, 1'b1);
    @(posedge clk_2);
    #2 reset = 1'b0;
    @(negedge clk_2);
    reset = 1'b1;
    count_busy(n0, n1);
    chk("restart sweep cycles u0", n0, 16);
    chk("restart sweep cycles u1", n1, 12);
    run_vec(0, "after restart addr4", '{1'b0, 4'd4, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    req0 = 1'b0;

`ifdef RAM_PARITY_EN
    err_inject0 = 1'b1;
    run_vec(0, "parity inject write", '{1'b1, 4'd5, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1});
    err_inject0 = 1'b0;
    run_vec(0, "parity bad read", '{1'b0, 4'd5, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1});
    chk("parity_err on bad word", parity_err0, 1'b1);
    run_vec(0, "parity good read", '{1'b0, 4'd6, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    chk("parity_err on good word", parity_err0, 1'b0);
    req0 = 1'b0;
    run_vec(1, "u1 wt write", '{1'b1, 4'd1, 8'h33, 1'b1, 8'h33, 1'b0, 1'b1});
    chk("no parity_err on write-through", parity_err1, 1'b0);
    req1 = 1'b0;
`endif

    @(negedge clk_2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
